gh_fifo_sync_param: RTL and testbench

- Single-clock synchronous FIFO.
- Parametrised successor to the team's fixed 16-deep FIFO, generalised in data width and depth (power of two).
- Adds occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Used as a generic buffer inside single-clock-domain datapaths (UART/SPI cores, bus bridges).

---
 rtl/gh_fifo_pkg.sv | 20 ++
 rtl/gh_fifo_sync_param_if.sv | 29 ++
 rtl/gh_sdp_ram.sv | 34 +++
 rtl/gh_fifo_sync_param.sv | 86 ++++++++
 tb/tb_gh_fifo_sync_param.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/gh_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package gh_fifo_pkg;

    localparam int def_data_width = 32'sd8;
    localparam int def_add_width  = 32'sd4;

    // Ceiling log2, used to size occupancy and pointer vectors from a depth.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 32'sd1;
        r = 32'sd0;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gh_fifo_sync_param_if.sv
// Data/handshake/status bundle between a FIFO user (master) and the FIFO (slave).
interface gh_fifo_sync_param_if
    import gh_fifo_pkg::*;
#(
    parameter int data_width = def_data_width,
    parameter int add_width  = def_add_width
);
    logic                  WR;
    logic                  RD;
    logic [data_width-1:0] D;
    logic [data_width-1:0] Q;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [add_width:0]    count;
    logic                  wr_err;
    logic                  rd_err;

    modport master (
        output WR, RD, D,
        input  Q, empty, full, almost_empty, almost_full, count, wr_err, rd_err
    );

    modport slave (
        input  WR, RD, D,
        output Q, empty, full, almost_empty, almost_full, count, wr_err, rd_err
    );
endinterface

// File: rtl/gh_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first).
module gh_sdp_ram #(
    parameter int data_width = 32'sd8,
    parameter int add_width  = 32'sd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [add_width-1:0]  wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [add_width-1:0]  rd_addr,
    output logic [data_width-1:0] rd_data
);
    localparam int depth = 32'sd1 << add_width;

    logic [data_width-1:0] mem_r [0:depth-1];

    // Write port; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port; only the output register is cleared, holds when not enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end
endmodule

// File: rtl/gh_fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty and sticky error flags.
module gh_fifo_sync_param
    import gh_fifo_pkg::*;
#(
    parameter int data_width = def_data_width,
    parameter int add_width  = def_add_width,
    parameter int af_level   = 32'sd12,
    parameter int ae_level   = 32'sd4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srst,
    gh_fifo_sync_param_if.slave  bus
);
    localparam int depth     = 32'sd1 << add_width;
    localparam int cnt_width = clog2(depth) + 32'sd1;

    typedef logic [cnt_width-1:0] ptr_t;

    localparam ptr_t af_thr = ptr_t'(af_level);
    localparam ptr_t ae_thr = ptr_t'(ae_level);

    ptr_t wr_ptr_r, rd_ptr_r, count_r;
    ptr_t wr_ptr_nx_s, rd_ptr_nx_s, count_nx_s;
    logic empty_r, full_r, ae_r, af_r, wr_err_r, rd_err_r;
    logic rd_ok_s, wr_ok_s, wr_en_s, rd_en_s;

    // Accept decisions from registered flags, then next pointers and occupancy.
    always_comb begin
        rd_ok_s     = bus.RD & ~empty_r;
        wr_ok_s     = bus.WR & (~full_r | rd_ok_s);
        wr_en_s     = wr_ok_s & rst_n & ~srst;
        rd_en_s     = rd_ok_s & rst_n & ~srst;
        wr_ptr_nx_s = wr_ptr_r + ptr_t'(wr_en_s);
        rd_ptr_nx_s = rd_ptr_r + ptr_t'(rd_en_s);
        count_nx_s  = wr_ptr_nx_s - rd_ptr_nx_s;
    end

    // Pointers and all status flags, computed from next state so none lags count.
    always_ff @(posedge clk) begin
        if (!rst_n || srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ae_r     <= 1'b1;
            af_r     <= 1'b0;
            wr_err_r <= 1'b0;
            rd_err_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            count_r  <= count_nx_s;
            empty_r  <= (wr_ptr_nx_s == rd_ptr_nx_s);
            full_r   <= (wr_ptr_nx_s[cnt_width-2:0] == rd_ptr_nx_s[cnt_width-2:0]) &
                        (wr_ptr_nx_s[cnt_width-1] != rd_ptr_nx_s[cnt_width-1]);
            ae_r     <= (count_nx_s <= ae_thr);
            af_r     <= (count_nx_s >= af_thr);
            wr_err_r <= wr_err_r | (bus.WR & ~wr_ok_s);
            rd_err_r <= rd_err_r | (bus.RD & empty_r);
        end
    end

    gh_sdp_ram #(
        .data_width (data_width),
        .add_width  (add_width)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[cnt_width-2:0]),
        .wr_data (bus.D),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r[cnt_width-2:0]),
        .rd_data (bus.Q)
    );

    assign bus.empty        = empty_r;
    assign bus.full         = full_r;
    assign bus.almost_empty = ae_r;
    assign bus.almost_full  = af_r;
    assign bus.count        = count_r;
    assign bus.wr_err       = wr_err_r;
    assign bus.rd_err       = rd_err_r;
endmodule

// File: tb/tb_gh_fifo_sync_param.sv
// Scoreboard bench: queue-based reference model, two DUTs differing only in thresholds.
module tb_gh_fifo_sync_param;
    import gh_fifo_pkg::*;

    localparam int dw    = 8;
    localparam int aw    = 4;
    localparam int depth = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, srst, wr, rd;
    logic [dw-1:0] d;

    gh_fifo_sync_param_if #(.data_width(dw), .add_width(aw)) bus_a ();
    gh_fifo_sync_param_if #(.data_width(dw), .add_width(aw)) bus_b ();

    assign bus_a.WR = wr;
    assign bus_a.RD = rd;
    assign bus_a.D  = d;
    assign bus_b.WR = wr;
    assign bus_b.RD = rd;
    assign bus_b.D  = d;

    gh_fifo_sync_param #(.data_width(dw), .add_width(aw), .af_level(12), .ae_level(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .srst(srst), .bus(bus_a.slave));
    gh_fifo_sync_param #(.data_width(dw), .add_width(aw), .af_level(3), .ae_level(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .srst(srst), .bus(bus_b.slave));

    typedef struct {
        logic [7:0] q;
        int         count;
        bit empty, full, ae, af, ae_b, af_b, wr_err, rd_err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    logic [7:0] m_q;
    bit         m_wr_err, m_rd_err;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances and the expected post-edge state is queued.
    task automatic cyc(input bit r_n, input bit s, input bit w, input bit r, input logic [7:0] din);
        exp_t e;
        bit   m_empty, m_full, rd_ok, wr_ok;
        @(negedge clk);
        rst_n = r_n; srst = s; wr = w; rd = r; d = din;
        if (!r_n) begin
            mq.delete(); m_q = 8'h00; m_wr_err = 0; m_rd_err = 0;
        end else if (s) begin
            mq.delete(); m_wr_err = 0; m_rd_err = 0;
        end else begin
            m_empty = (mq.size() == 0);
            m_full  = (mq.size() == depth);
            rd_ok   = r && !m_empty;
            wr_ok   = w && (!m_full || rd_ok);
            if (r && m_empty) m_rd_err = 1;
            if (w && !wr_ok)  m_wr_err = 1;
            if (rd_ok) m_q = mq.pop_front();
            if (wr_ok) mq.push_back(din);
        end
        e.q      = m_q;
        e.count  = mq.size();
        e.empty  = (mq.size() == 0);
        e.full   = (mq.size() == depth);
        e.ae     = (mq.size() <= 4);
        e.af     = (mq.size() >= 12);
        e.ae_b   = (mq.size() <= 1);
        e.af_b   = (mq.size() >= 3);
        e.wr_err = m_wr_err;
        e.rd_err = m_rd_err;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge compare both DUTs to the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q",            32'(bus_a.Q),            32'(e.q));
                chk("count",        32'(bus_a.count),        32'(e.count));
                chk("empty",        32'(bus_a.empty),        32'(e.empty));
                chk("full",         32'(bus_a.full),         32'(e.full));
                chk("almost_empty", 32'(bus_a.almost_empty), 32'(e.ae));
                chk("almost_full",  32'(bus_a.almost_full),  32'(e.af));
                chk("wr_err",       32'(bus_a.wr_err),       32'(e.wr_err));
                chk("rd_err",       32'(bus_a.rd_err),       32'(e.rd_err));
                chk("q_b",          32'(bus_b.Q),            32'(e.q));
                chk("count_b",      32'(bus_b.count),        32'(e.count));
                chk("almost_empty_b", 32'(bus_b.almost_empty), 32'(e.ae_b));
                chk("almost_full_b",  32'(bus_b.almost_full),  32'(e.af_b));
            end
        end
    end

    initial begin
        bit r_n, s;
        rst_n = 1'b0; srst = 1'b0; wr = 1'b0; rd = 1'b0; d = 8'h00;
        m_q = 8'h00; m_wr_err = 0; m_rd_err = 0;

        // reset held two clocks while writing
        cyc(0, 0, 1, 0, 8'h33);
        cyc(0, 0, 1, 0, 8'h44);

        // fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) cyc(1, 0, 1, 0, 8'(i));
        cyc(1, 0, 1, 0, 8'h77);
        for (int i = 0; i < 17; i++) cyc(1, 0, 0, 1, 8'h00);

        // simultaneous access at full, then at empty
        cyc(1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1, 0, 1, 0, 8'(8'h10 + i));
        cyc(1, 0, 1, 1, 8'hA5);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 1, 8'h00);
        cyc(1, 0, 1, 1, 8'h5A);
        cyc(1, 0, 0, 1, 8'h00);

        // wrap-around at constant occupancy of five
        cyc(1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++)  cyc(1, 0, 1, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) cyc(1, 0, 1, 1, 8'($urandom));

        // soft reset mid-operation at occupancy nine
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 8'($urandom));
        cyc(1, 1, 1, 1, 8'hEE);
        cyc(1, 0, 1, 0, 8'h3C);
        cyc(1, 0, 0, 1, 8'h00);

        // threshold stepping 0..4..0
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 8'($urandom));
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'h00);

        // randomized traffic with phase-dependent write/read bias
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp  = (i % 150 < 75) ? 70 : 30;
            r_n = ($urandom_range(0, 199) != 0);
            s   = ($urandom_range(0, 59) == 0);
            cyc(r_n, s, ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < 100 - wp),
                8'($urandom));
        end
        cyc(1, 0, 0, 0, 8'h00);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
